// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared types and helpers for the slice-serial adder.
// Optional subtract mode is enabled by defining ADDER_SEQ_SUB_EN.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width, never narrower than one bit.
  function automatic int idx_width(input int nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/adder_seq_slice.sv
// adder_seq_slice: combinational SLICE-bit ripple adder
// built from generated 1-bit full-adder cells.
module adder_seq_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] res,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign res[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/adder_seq.sv
// adder_seq: WIDTH-bit add through one SLICE-bit adder, LSB slice first.
// Define ADDER_SEQ_SUB_EN to add the in_sub port (A + ~B + 1).
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             busy
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = idx_width(NSL);
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("adder_seq: WIDTH must be a multiple of SLICE");
  end

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [SLICE-1:0] s_a;
  logic [SLICE-1:0] s_b;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  int               base;

`ifdef ADDER_SEQ_SUB_EN
  assign b_in = in_sub ? ~in_b : in_b;
  assign c_in = in_sub ? 1'b1 : in_cin;
`else
  assign b_in = in_b;
  assign c_in = in_cin;
`endif

  // Select the active slice and merge its sum into the result word.
  always_comb begin
    base    = int'(idx) * SLICE;
    s_a     = a_reg[base +: SLICE];
    s_b     = b_reg[base +: SLICE];
    res_nxt = res_reg;
    res_nxt[base +: SLICE] = s_sum;
  end

  adder_seq_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry),
    .res  (s_sum),
    .cout (s_cout)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      out_res   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= b_in;
            carry    <= c_in;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          res_reg <= res_nxt;
          carry   <= s_cout;
          if (idx == LAST) begin
            out_res   <= res_nxt;
            out_cout  <= s_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq: directed and random checks of adder_seq,
// plus a SLICE==WIDTH instance for the single-slice case.
module tb_adder_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_res;
  logic        out_cout;
  logic        busy;

  logic        o_in_valid = 1'b0;
  logic        o_in_ready;
  logic [31:0] o_in_a = '0;
  logic [31:0] o_in_b = '0;
  logic        o_out_valid;
  logic        o_out_ready = 1'b0;
  logic [31:0] o_out_res;
  logic        o_out_cout;
  logic        o_busy;

  int total  = 0;
  int passed = 0;
  int lat;

  always #5 clk = ~clk;

  adder_seq #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADDER_SEQ_SUB_EN
    .in_sub    (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  adder_seq #(.WIDTH(32), .SLICE(32)) u_one (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (o_in_valid),
    .in_ready  (o_in_ready),
    .in_a      (o_in_a),
    .in_b      (o_in_b),
    .in_cin    (1'b0),
`ifdef ADDER_SEQ_SUB_EN
    .in_sub    (1'b0),
`endif
    .out_valid (o_out_valid),
    .out_ready (o_out_ready),
    .out_res   (o_out_res),
    .out_cout  (o_out_cout),
    .busy      (o_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Hand operands over and wait (bounded) for out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic s);
    in_a = a; in_b = b; in_cin = cin; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] ex;
    logic        seen;

    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res", 64'({out_cout, out_res}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("ovf_lat", 64'(lat), 64'd5);
    check("ovf_res", 64'({out_cout, out_res}), 64'h1_0000_0000);

    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a = 32'h0000_1111;
      in_b = 32'h0000_2222;
      @(posedge clk); #1;
      check("bp_hold",
            64'({out_valid, in_ready, busy, out_cout, out_res}),
            {29'd0, 3'b101, 1'b1, 32'h0});
    end
    in_valid = 1'b0;
    release_out();
    check("bp_release", 64'({out_valid, in_ready}), 64'b01);
    check("bp_res_kept", 64'({out_cout, out_res}), 64'h1_0000_0000);
    @(posedge clk); #1;
    check("bp_no_accept", 64'({busy, out_valid}), 64'd0);

    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    check("mix_lat", 64'(lat), 64'd5);
    check("mix_res", 64'({out_cout, out_res}), 64'h0_2345_678A);
    release_out();

`ifdef ADDER_SEQ_SUB_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1);
    check("sub_neg", 64'({out_cout, out_res}), 64'h0_FFFF_FFFE);
    release_out();
    run_op(32'd7, 32'd5, 1'b0, 1'b1);
    check("sub_pos", 64'({out_cout, out_res}), 64'h1_0000_0002);
    release_out();
`endif

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1));
      ex = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      run_op(ra, rb, rc, 1'b0);
      check("rand", 64'({out_valid, out_cout, out_res}), {30'd0, 1'b1, ex});
      release_out();
    end

    in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555; in_cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out",
          64'({in_ready, out_valid, busy, out_cout, out_res}),
          {29'd0, 3'b100, 1'b0, 32'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);

    o_in_a = 32'h8000_0000;
    o_in_b = 32'h8000_0000;
    o_in_valid = 1'b1;
    @(posedge clk); #1;
    o_in_valid = 1'b0;
    lat = 1;
    while (!o_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("one_lat", 64'(lat), 64'd2);
    check("one_res", 64'({o_out_cout, o_out_res}), 64'h1_0000_0000);
    o_out_ready = 1'b1;
    @(posedge clk); #1;
    o_out_ready = 1'b0;
    check("one_release", 64'({o_out_valid, o_in_ready}), 64'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
